fft32_pipe_ctrl: RTL and testbench

FFT32_PIPE_CTRL -- requirements
Module: fft32_pipe_ctrl

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft32_pipe_ctrl_if.sv | 37 +++
 rtl/fft32_pipe_ctrl.sv | 85 ++++++++
 tb/tb_fft32_pipe_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and helpers for the 32-point FFT pipeline.
// The control block and its bus interface both import this package.
package fft_pkg;

    localparam int FFT_LOG2       = 5;
    localparam int FFT_POINTS     = 1 << FFT_LOG2;
    // One input register plus one butterfly stage per radix-2 pass.
    localparam int FFT_PIPE_DEPTH = FFT_LOG2 + 1;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } fft_state_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/fft32_pipe_ctrl_if.sv
// Frame handshake, flush and status bundle between the FFT pipeline controller
// and its parent. The controller side is the master modport.
interface fft32_pipe_ctrl_if #(
    parameter int L  = fft_pkg::FFT_PIPE_DEPTH,
    parameter int CW = 16
);
    import fft_pkg::*;

    // Handshakes: a transfer happens in every cycle where valid and ready are
    // both high at the rising edge; ready may depend combinationally on the
    // other side's ready, never on its own valid.
    logic                   in_valid;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic [L-1:0]           stage_en;
    logic                   flush_req;
    logic                   flush_done;
    logic                   busy;
    logic [$clog2(L+1)-1:0] occupancy;
    logic [CW-1:0]          in_count;
    logic [CW-1:0]          out_count;
    fft_state_e             state;

    modport master (
        input  in_valid, out_ready, flush_req,
        output in_ready, out_valid, stage_en, flush_done, busy, occupancy,
               in_count, out_count, state
    );

    modport slave (
        output in_valid, out_ready, flush_req,
        input  in_ready, out_valid, stage_en, flush_done, busy, occupancy,
               in_count, out_count, state
    );

endinterface

// File: rtl/fft32_pipe_ctrl.sv
// Valid/enable controller for the L-stage FFT datapath: collapses bubbles under
// backpressure, drains on request and counts frames in and out.
module fft32_pipe_ctrl
    import fft_pkg::*;
#(
    parameter int L  = FFT_PIPE_DEPTH,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              rst,
    fft32_pipe_ctrl_if.master bus
);

    localparam int OW = $clog2(L + 1);

    logic [L-1:0]  vld;
    logic [L-1:0]  en;
    logic [OW-1:0] occ;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic          in_rdy;
    logic          in_hs;
    logic          out_hs;
    fft_state_e    state;
    fft_state_e    state_nxt;

    // Unrolled form of en[k] = !vld[k] | en[k+1]: a stage may load when
    // downstream accepts or any stage at or after it holds a bubble.
    for (genvar k = 0; k < L; k++) begin : g_en
        assign en[k] = bus.out_ready | ~(&vld[L-1:k]);
    end

    assign occ    = OW'(popcount(32'(vld)));
    assign in_rdy = en[0] & (state == ACCEPT);
    assign in_hs  = bus.in_valid & in_rdy;
    assign out_hs = vld[L-1] & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            if (en[0]) vld[0] <= in_hs;
            for (int k = 1; k < L; k++) begin
                if (en[k]) vld[k] <= vld[k-1];
            end
        end
    end

    // Flush is only honoured in ACCEPT; DRAIN exits as soon as the pipe is empty.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCEPT:  if (bus.flush_req) state_nxt = DRAIN;
            DRAIN:   if (occ == '0) state_nxt = DONE;
            DONE:    state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCEPT;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (in_hs)  in_cnt  <= in_cnt + 1'b1;
            if (out_hs) out_cnt <= out_cnt + 1'b1;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = vld[L-1];
    assign bus.stage_en   = en;
    assign bus.flush_done = (state == DONE);
    assign bus.busy       = |vld;
    assign bus.occupancy  = occ;
    assign bus.in_count   = in_cnt;
    assign bus.out_count  = out_cnt;
    assign bus.state      = state;

endmodule

// File: tb/tb_fft32_pipe_ctrl.sv
// Directed bench for fft32_pipe_ctrl: scoreboard of accepted frames checked
// for order, count and latency at each delivery.
module tb_fft32_pipe_ctrl;
    import fft_pkg::*;

    localparam int L  = 6;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fft32_pipe_ctrl_if #(.L(L), .CW(CW)) bus ();
    fft32_pipe_ctrl #(.L(L), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nvec    = 0;
    int nerr    = 0;
    int cyc_n   = 0;
    int acc_idx = 0;
    bit lat_chk = 1'b0;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called mid-cycle: records accepts and scores deliveries.
    task automatic mon();
        logic [63:0]   e;
        logic [CW-1:0] ai;
        if (rst) return;
        if (bus.in_valid && bus.in_ready) begin
            ai = acc_idx[CW-1:0];
            chk("in_count_at_accept", 32'(bus.in_count), 32'(ai));
            exp_q.push_back({32'(acc_idx), 32'(cyc_n)});
            acc_idx++;
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("out_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_order", 32'(bus.out_count), 32'(e[32 +: CW]));
                if (lat_chk) chk("latency", 32'(cyc_n) - e[31:0], 32'(L));
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    initial begin
        int peak;
        int first;
        int last;
        int nout;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush_req = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_flush_done", 32'(bus.flush_done), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_stage_en", 32'(bus.stage_en), 32'h3f);
        chk("rst_in_count", 32'(bus.in_count), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_state", 32'(bus.state), 32'(ACCEPT));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single frame, latency L
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        lat_chk       = 1'b1;
        #1 chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1 chk("t1_out_valid", 32'(bus.out_valid), 32'(i == 6));
            cyc();
        end
        chk("t1_in_count", 32'(bus.in_count), 32'd1);
        chk("t1_out_count", 32'(bus.out_count), 32'd1);

        // 10 back-to-back frames
        peak = 0; first = -1; last = -1; nout = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (i < 10);
            #1;
            chk("t2_in_ready", 32'(bus.in_ready), 32'd1);
            if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
            if (bus.out_valid) begin
                if (first < 0) first = i;
                last = i;
                nout++;
            end
            cyc();
        end
        chk("t2_out_cycles", 32'(nout), 32'd10);
        chk("t2_out_span", 32'(last - first), 32'd9);
        chk("t2_peak_occ", 32'(peak), 32'd6);
        chk("t2_in_count", 32'(bus.in_count), 32'd11);
        chk("t2_out_count", 32'(bus.out_count), 32'd11);

        // spaced frames collapse under backpressure
        lat_chk       = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i == 0 || i == 2 || i == 4);
            #1;
            if (i == 0 || i == 2 || i == 4) chk("t3_in_ready", 32'(bus.in_ready), 32'd1);
            cyc();
        end
        bus.in_valid = 1'b0;
        #1;
        chk("t3_occupancy", 32'(bus.occupancy), 32'd3);
        chk("t3_stage_en", 32'(bus.stage_en), 32'b000111);
        chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_out_count_held", 32'(bus.out_count), 32'd11);
        bus.out_ready = 1'b1;
        repeat (8) cyc();
        chk("t3_drained_occ", 32'(bus.occupancy), 32'd0);
        chk("t3_out_count", 32'(bus.out_count), 32'd14);
        chk("t3_in_count", 32'(bus.in_count), 32'd14);
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // full pipe, single-cycle release
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (8) cyc();
        #1;
        chk("t4_full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t4_full_stage_en", 32'(bus.stage_en), 32'd0);
        chk("t4_full_occ", 32'(bus.occupancy), 32'd6);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("t4_release_stage_en", 32'(bus.stage_en), 32'h3f);
        chk("t4_release_in_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.out_ready = 1'b0;
        #1;
        chk("t4_after_occ", 32'(bus.occupancy), 32'd5);
        chk("t4_after_stage_en", 32'(bus.stage_en), 32'b000001);
        chk("t4_after_out_count", 32'(bus.out_count), 32'd15);
        chk("t4_in_count", 32'(bus.in_count), 32'd20);
        repeat (2) cyc();
        chk("t4_hold_occ", 32'(bus.occupancy), 32'd5);
        chk("t4_hold_out_count", 32'(bus.out_count), 32'd15);
        bus.out_ready = 1'b1;
        repeat (8) cyc();
        chk("t4_drained_occ", 32'(bus.occupancy), 32'd0);
        chk("t4_out_count", 32'(bus.out_count), 32'd20);

        // flush with 4 frames, last one accepted in the flush cycle
        lat_chk       = 1'b1;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 14; j++) begin
            bus.in_valid  = (j < 12);
            bus.flush_req = (j == 3 || j == 11);
            #1;
            chk("t5_in_ready", 32'(bus.in_ready), 32'(j <= 3 || j >= 12));
            chk("t5_flush_done", 32'(bus.flush_done), 32'(j == 11));
            if (j == 5) chk("t5_state_drain", 32'(bus.state), 32'(DRAIN));
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.flush_req = 1'b0;
        chk("t5_in_count", 32'(bus.in_count), 32'd24);
        chk("t5_out_count", 32'(bus.out_count), 32'd24);

        // flush on an empty pipe
        bus.flush_req = 1'b1;
        #1 chk("t5e_c0_flush_done", 32'(bus.flush_done), 32'd0);
        cyc();
        bus.flush_req = 1'b0;
        #1;
        chk("t5e_c1_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t5e_c1_flush_done", 32'(bus.flush_done), 32'd0);
        cyc();
        #1 chk("t5e_c2_flush_done", 32'(bus.flush_done), 32'd1);
        cyc();
        #1;
        chk("t5e_c3_flush_done", 32'(bus.flush_done), 32'd0);
        chk("t5e_c3_in_ready", 32'(bus.in_ready), 32'd1);

        // counter wrap
        bus.in_valid = 1'b1;
        repeat (65535 - 24) cyc();
        bus.in_valid = 1'b0;
        #1 chk("t6_in_count_max", 32'(bus.in_count), 32'hffff);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        #1 chk("t6_in_count_wrap", 32'(bus.in_count), 32'd0);
        repeat (8) cyc();
        chk("t6_out_count_wrap", 32'(bus.out_count), 32'd0);
        chk("t6_occ", 32'(bus.occupancy), 32'd0);

        // reset in the middle of a drain
        lat_chk       = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (3) cyc();
        bus.in_valid  = 1'b0;
        bus.flush_req = 1'b1;
        cyc();
        bus.flush_req = 1'b0;
        repeat (2) cyc();
        chk("t7_state_drain", 32'(bus.state), 32'(DRAIN));
        chk("t7_occ_before", 32'(bus.occupancy), 32'd3);
        rst = 1'b1;
        #1;
        chk("t7_rst_occ", 32'(bus.occupancy), 32'd0);
        chk("t7_rst_busy", 32'(bus.busy), 32'd0);
        chk("t7_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t7_rst_flush_done", 32'(bus.flush_done), 32'd0);
        chk("t7_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t7_rst_stage_en", 32'(bus.stage_en), 32'h3f);
        exp_q.delete();
        acc_idx = 0;
        repeat (2) cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t7_no_flush_done", 32'(bus.flush_done), 32'd0);
            chk("t7_state_accept", 32'(bus.state), 32'(ACCEPT));
            chk("t7_occ_after", 32'(bus.occupancy), 32'd0);
            cyc();
        end
        chk("t7_in_count", 32'(bus.in_count), 32'd0);
        chk("t7_out_count", 32'(bus.out_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
